// File: rtl/fb_scanout.sv
// 640x480@60 scanout for the 1-bit framebuffer: VGA timing, sequential RAM read address, latency-matched outputs.
// Optional build macro FB_SCANOUT_BORDER_EN forces a one-pixel white border around the visible area.
module fb_scanout #(
    parameter int unsigned H_VISIBLE   = 640,
    parameter int unsigned H_FRONT     = 16,
    parameter int unsigned H_SYNC      = 96,
    parameter int unsigned H_BACK      = 48,
    parameter int unsigned V_VISIBLE   = 480,
    parameter int unsigned V_FRONT     = 10,
    parameter int unsigned V_SYNC      = 2,
    parameter int unsigned V_BACK      = 33,
    parameter int unsigned RAM_LATENCY = 1,
    parameter int unsigned ADDR_W      = 19
) (
    input  logic              CLOCK,
    input  logic              RESET_N,
    output logic [ADDR_W-1:0] RD_ADDR,
    input  logic              RD_DATA,
    output logic              VGA_HS,
    output logic              VGA_VS,
    output logic              VGA_RED,
    output logic              VGA_GREEN,
    output logic              VGA_BLUE,
    output logic              IS_DRAWING,
    output logic              FRAME_START
);

    localparam int unsigned H_TOTAL  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL  = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int unsigned HW       = $clog2(H_TOTAL);
    localparam int unsigned VW       = $clog2(V_TOTAL);
    localparam int unsigned HS_START = H_VISIBLE + H_FRONT;
    localparam int unsigned HS_END   = HS_START + H_SYNC;
    localparam int unsigned VS_START = V_VISIBLE + V_FRONT;
    localparam int unsigned VS_END   = VS_START + V_SYNC;

    // Term vector bit positions; sync bits are stored active-low.
    localparam int unsigned T_VIS = 0;
    localparam int unsigned T_HS  = 1;
    localparam int unsigned T_VS  = 2;
    localparam int unsigned T_FS  = 3;
`ifdef FB_SCANOUT_BORDER_EN
    localparam int unsigned T_EX  = 4;
    localparam int unsigned T_EY  = 5;
    localparam int unsigned TW    = 6;
`else
    localparam int unsigned TW    = 4;
`endif
    localparam logic [TW-1:0] T_IDLE = TW'(4'b0110);

    logic [HW-1:0]     h;
    logic [VW-1:0]     v;
    logic [ADDR_W-1:0] addr;
    logic              h_last;
    logic              v_last;
    logic              vis0;
    logic              last_pix;
    logic [TW-1:0]     t0;
    logic [TW-1:0]     td;
    logic              pix;

    assign h_last   = (h == HW'(H_TOTAL - 1));
    assign v_last   = (v == VW'(V_TOTAL - 1));
    assign vis0     = (h < HW'(H_VISIBLE)) && (v < VW'(V_VISIBLE));
    assign last_pix = (h == HW'(H_VISIBLE - 1)) && (v == VW'(V_VISIBLE - 1));
    assign RD_ADDR  = addr;

    // Raster counters
    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            h <= '0;
            v <= '0;
        end else if (h_last) begin
            h <= '0;
            v <= v_last ? '0 : v + VW'(1);
        end else begin
            h <= h + HW'(1);
        end
    end

    // Running read address tracks v*H_VISIBLE+h without a multiplier
    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            addr <= '0;
        end else if (vis0) begin
            addr <= last_pix ? '0 : addr + ADDR_W'(1);
        end
    end

    // Stage-0 terms
    always_comb begin
        t0        = '0;
        t0[T_VIS] = vis0;
        t0[T_HS]  = !((h >= HW'(HS_START)) && (h < HW'(HS_END)));
        t0[T_VS]  = !((v >= VW'(VS_START)) && (v < VW'(VS_END)));
        t0[T_FS]  = (h == '0) && (v == '0);
`ifdef FB_SCANOUT_BORDER_EN
        t0[T_EX]  = (h == '0) || (h == HW'(H_VISIBLE - 1));
        t0[T_EY]  = (v == '0) || (v == VW'(V_VISIBLE - 1));
`endif
    end

    // Delay terms to line up with RD_DATA
    generate
        if (RAM_LATENCY == 0) begin : g_nodly
            assign td = t0;
        end else begin : g_dly
            logic [TW-1:0] sr [RAM_LATENCY];
            always_ff @(posedge CLOCK or negedge RESET_N) begin
                if (!RESET_N) begin
                    for (int i = 0; i < RAM_LATENCY; i++) sr[i] <= T_IDLE;
                end else begin
                    sr[0] <= t0;
                    for (int i = 1; i < RAM_LATENCY; i++) sr[i] <= sr[i-1];
                end
            end
            assign td = sr[RAM_LATENCY-1];
        end
    endgenerate

`ifdef FB_SCANOUT_BORDER_EN
    assign pix = RD_DATA | td[T_EX] | td[T_EY];
`else
    assign pix = RD_DATA;
`endif

    // Output register; pixel data is blanked outside the visible area
    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            VGA_HS      <= 1'b1;
            VGA_VS      <= 1'b1;
            VGA_RED     <= 1'b0;
            VGA_GREEN   <= 1'b0;
            VGA_BLUE    <= 1'b0;
            IS_DRAWING  <= 1'b0;
            FRAME_START <= 1'b0;
        end else begin
            VGA_HS      <= td[T_HS];
            VGA_VS      <= td[T_VS];
            VGA_RED     <= td[T_VIS] & pix;
            VGA_GREEN   <= td[T_VIS] & pix;
            VGA_BLUE    <= td[T_VIS] & pix;
            IS_DRAWING  <= td[T_VIS];
            FRAME_START <= td[T_FS];
        end
    end

endmodule

// File: tb/tb_fb_scanout.sv
// Directed bench for fb_scanout: full-size timing (latency 1 and 3) plus a shrunken raster for frame wrap.
module tb_fb_scanout;

    logic        CLOCK;
    logic        RESET_N;

    logic [18:0] a_addr, l_addr, s_addr;
    logic        a_rd, l_rd;
    logic [2:0]  l_pipe;
    logic        a_hs, a_vs, a_r, a_g, a_b, a_id, a_fs;
    logic        l_hs, l_vs, l_r, l_g, l_b, l_id, l_fs;
    logic        s_hs, s_vs, s_r, s_g, s_b, s_id, s_fs;

    int errors;
    int checks;

    initial CLOCK = 1'b0;
    always #5 CLOCK = ~CLOCK;

    // RAM models: latency 1 returning addr[0], latency 3 returning addr==1000
    always @(posedge CLOCK) a_rd <= a_addr[0];
    always @(posedge CLOCK) l_pipe <= {l_pipe[1:0], (l_addr == 19'd1000)};
    assign l_rd = l_pipe[2];

    fb_scanout u_dut (
        .CLOCK(CLOCK), .RESET_N(RESET_N), .RD_ADDR(a_addr), .RD_DATA(a_rd),
        .VGA_HS(a_hs), .VGA_VS(a_vs), .VGA_RED(a_r), .VGA_GREEN(a_g), .VGA_BLUE(a_b),
        .IS_DRAWING(a_id), .FRAME_START(a_fs)
    );

    fb_scanout #(.RAM_LATENCY(3)) u_l3 (
        .CLOCK(CLOCK), .RESET_N(RESET_N), .RD_ADDR(l_addr), .RD_DATA(l_rd),
        .VGA_HS(l_hs), .VGA_VS(l_vs), .VGA_RED(l_r), .VGA_GREEN(l_g), .VGA_BLUE(l_b),
        .IS_DRAWING(l_id), .FRAME_START(l_fs)
    );

    fb_scanout #(
        .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
        .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1)
    ) u_sm (
        .CLOCK(CLOCK), .RESET_N(RESET_N), .RD_ADDR(s_addr), .RD_DATA(1'b0),
        .VGA_HS(s_hs), .VGA_VS(s_vs), .VGA_RED(s_r), .VGA_GREEN(s_g), .VGA_BLUE(s_b),
        .IS_DRAWING(s_id), .FRAME_START(s_fs)
    );

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Expected {fs, vs, hs, vis, r, g, b} after n edges since reset release.
    // mode 0: RAM returns 0; 1: addr[0]; 2: addr==1000.
    function automatic logic [6:0] exp_out(int n, int lat, int hv, int hf, int hsw, int hb,
                                           int vv, int vf, int vsw, int vb, int mode);
        int q, ht, vt, x, y, addr;
        logic vis, hsl, vsl, fs, rd, col;
        if (n < lat + 1) return 7'b0110000;
        q    = n - lat - 1;
        ht   = hv + hf + hsw + hb;
        vt   = vv + vf + vsw + vb;
        x    = q % ht;
        y    = (q / ht) % vt;
        vis  = (x < hv) && (y < vv);
        hsl  = (x >= hv + hf) && (x < hv + hf + hsw);
        vsl  = (y >= vv + vf) && (y < vv + vf + vsw);
        fs   = (x == 0) && (y == 0);
        addr = y * hv + x;
        rd   = (mode == 1) ? addr[0] : (mode == 2) ? (addr == 1000) : 1'b0;
`ifdef FB_SCANOUT_BORDER_EN
        rd   = rd | (x == 0) | (x == hv - 1) | (y == 0) | (y == vv - 1);
`endif
        col  = vis & rd;
        return {fs, !vsl, !hsl, vis, col, col, col};
    endfunction

    initial begin
        int bad_a, bad_l, bad_s;
        int a_hs_lo, a_id_cnt;
        int s_hs_lo, s_vs_lo, s_id_cnt, s_fs_cnt, s_white, s_max;
        errors = 0; checks = 0;
        bad_a = 0; bad_l = 0; bad_s = 0;
        a_hs_lo = 0; a_id_cnt = 0;
        s_hs_lo = 0; s_vs_lo = 0; s_id_cnt = 0; s_fs_cnt = 0; s_white = 0; s_max = 0;

        RESET_N = 1'b0;
        repeat (5) @(posedge CLOCK);
        @(negedge CLOCK);
        check("rst_hs", int'(a_hs), 1);
        check("rst_vs", int'(a_vs), 1);
        check("rst_red", int'(a_r), 0);
        check("rst_drawing", int'(a_id), 0);
        check("rst_fs", int'(a_fs), 0);
        check("rst_addr", int'(a_addr), 0);

        RESET_N = 1'b1;
        check("addr_0_0", int'(a_addr), 0);

        for (int n = 1; n <= 1900; n++) begin
            @(negedge CLOCK);
            if ({a_fs, a_vs, a_hs, a_id, a_r, a_g, a_b} !== exp_out(n, 1, 640, 16, 96, 48, 480, 10, 2, 33, 1))
                bad_a++;
            if ({l_fs, l_vs, l_hs, l_id, l_r, l_g, l_b} !== exp_out(n, 3, 640, 16, 96, 48, 480, 10, 2, 33, 2))
                bad_l++;
            if ({s_fs, s_vs, s_hs, s_id, s_r, s_g, s_b} !== exp_out(n, 1, 8, 2, 3, 2, 4, 1, 2, 1, 0))
                bad_s++;
            if (n >= 2 && n < 802) begin
                if (!a_hs) a_hs_lo++;
                if (a_id) a_id_cnt++;
            end
            if (n >= 2 && n < 242) begin
                if (!s_hs) s_hs_lo++;
                if (!s_vs) s_vs_lo++;
                if (s_id) s_id_cnt++;
                if (s_fs) s_fs_cnt++;
                if (s_r) s_white++;
            end
            if (int'(s_addr) > s_max) s_max = int'(s_addr);

            if (n == 1)    check("fs_edge1", int'(a_fs), 0);
            if (n == 2)    check("fs_edge2", int'(a_fs), 1);
            if (n == 3)    check("fs_edge3", int'(a_fs), 0);
            if (n == 3)    check("l3_fs_edge3", int'(l_fs), 0);
            if (n == 4)    check("l3_fs_edge4", int'(l_fs), 1);
            if (n == 639)  check("addr_639_0", int'(a_addr), 639);
            if (n == 640)  check("addr_blank_start", int'(a_addr), 640);
            if (n == 799)  check("addr_blank_end", int'(a_addr), 640);
            if (n == 800)  check("addr_0_1", int'(a_addr), 640);
            if (n == 801)  check("addr_1_1", int'(a_addr), 641);
            if (n == 641)  check("red_x639", int'(a_r), 1);
            if (n == 642)  check("red_blank", int'(a_r), 0);
            if (n == 642)  check("drawing_blank", int'(a_id), 0);
            if (n == 806)  check("red_x4_y1", int'(a_r), 0);
            if (n == 807)  check("red_x5_y1", int'(a_r), 1);
            if (n == 657)  check("hs_before", int'(a_hs), 1);
            if (n == 658)  check("hs_fall", int'(a_hs), 0);
            if (n == 1160) check("l3_addr_1000", int'(l_addr), 1000);
            if (n == 1163) check("l3_red_x359", int'(l_r), 0);
            if (n == 1164) check("l3_red_x360", int'(l_r), 1);
            if (n == 1164) check("l3_drawing_x360", int'(l_id), 1);
            if (n == 1165) check("l3_red_x361", int'(l_r), 0);
            if (n == 52)   check("sm_addr_last", int'(s_addr), 31);
            if (n == 53)   check("sm_addr_wrap", int'(s_addr), 0);
            if (n == 121)  check("sm_addr_frame2", int'(s_addr), 1);
            if (n == 76)   check("sm_vs_before", int'(s_vs), 1);
            if (n == 77)   check("sm_vs_fall", int'(s_vs), 0);
        end

        check("main_stream_bad", bad_a, 0);
        check("l3_stream_bad", bad_l, 0);
        check("sm_stream_bad", bad_s, 0);
        check("hs_low_line0", a_hs_lo, 96);
        check("drawing_line0", a_id_cnt, 640);
        check("sm_hs_low", s_hs_lo, 48);
        check("sm_vs_low", s_vs_lo, 60);
        check("sm_drawing", s_id_cnt, 64);
        check("sm_fs_count", s_fs_cnt, 2);
`ifdef FB_SCANOUT_BORDER_EN
        check("sm_border_white", s_white, 40);
`else
        check("sm_white", s_white, 0);
`endif
        check("sm_addr_max", s_max, 31);

        // Mid-line asynchronous reset at h=300 of line 2
        check("pre_rst_drawing", int'(a_id), 1);
        check("pre_rst_addr", int'(a_addr), 1580);
        RESET_N = 1'b0;
        #1;
        check("async_hs", int'(a_hs), 1);
        check("async_vs", int'(a_vs), 1);
        check("async_red", int'(a_r), 0);
        check("async_drawing", int'(a_id), 0);
        check("async_addr", int'(a_addr), 0);
        check("async_l3_drawing", int'(l_id), 0);
        repeat (3) @(negedge CLOCK);
        RESET_N = 1'b1;
        for (int m = 1; m <= 3; m++) begin
            @(negedge CLOCK);
            check($sformatf("rerst_fs_edge%0d", m), int'(a_fs), (m == 2) ? 1 : 0);
            if (m == 2) check("rerst_addr", int'(a_addr), 2);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
